// File: rtl/lzc_pkg.sv
// Shared definitions for the pipelined leading-count / normalise unit.
package lzc_pkg;

   localparam logic MODE_LZ = 1'b0;
   localparam logic MODE_LO = 1'b1;

   // Per-nibble partial result: leading-zero count (0..4) and all-zero flag.
   typedef struct packed {
      logic       all;
      logic [2:0] cnt;
   } lzc_nib_t;

   // Width needed to hold a count in the range 0..w.
   function automatic int lzc_cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

   // Leading-zero count of one nibble, MSB first.
   function automatic lzc_nib_t lzc_nib(input logic [3:0] x);
      lzc_nib_t n;
      n.all = 1'b0;
      if (x[3])      n.cnt = 3'd0;
      else if (x[2]) n.cnt = 3'd1;
      else if (x[1]) n.cnt = 3'd2;
      else if (x[0]) n.cnt = 3'd3;
      else begin
         n.cnt = 3'd4;
         n.all = 1'b1;
      end
      return n;
   endfunction

endpackage

// File: rtl/lzc_merge.sv
// Combinational merge of two adjacent (count, all) pairs. The high half
// covers the more significant bits; when it is all-zero its count equals its
// span, so the merged count is simply the sum.
module lzc_merge #(
   parameter int CW = 5
) (
   input  logic [CW-1:0] i_hi_cnt,
   input  logic          i_hi_all,
   input  logic [CW-1:0] i_lo_cnt,
   input  logic          i_lo_all,
   output logic [CW-1:0] o_cnt,
   output logic          o_all
);

   // Extend into the low half only when the high half is fully matched.
   always_comb begin
      o_cnt = i_hi_cnt;
      o_all = 1'b0;
      if (i_hi_all) begin
         o_cnt = i_hi_cnt + i_lo_cnt;
         o_all = i_lo_all;
      end
   end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading-zero/one count and normalise with valid/ready stall chain.
// Stage 1 registers per-nibble results; the final stage merges the nibble tree
// and performs the barrel shift. Any stages in between are plain delay slots.
module lzc_pipe
   import lzc_pkg::*;
#(
   parameter  int W      = 16,
   parameter  int STAGES = 2,
   localparam int CNT_W  = lzc_cnt_w(W)
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [W-1:0]     data_i,
   input  logic             mode_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [W-1:0]     norm_o,
   output logic             all_o
);

   localparam int NIB = W / 4;

   logic [STAGES:1]        r_v;
   logic [STAGES:1]        w_vin;
   logic [STAGES+1:1]      w_adv;
   logic [W-1:0]           w_x;
   lzc_nib_t [NIB-1:0]     w_in_nib;
   logic [W-1:0]           w_src_data;
   lzc_nib_t [NIB-1:0]     w_src_nib;
   logic [CNT_W-1:0]       w_tcnt [0:2*NIB-2];
   logic                   w_tall [0:2*NIB-2];
   logic [CNT_W-1:0]       r_cnt;
   logic [W-1:0]           r_norm;
   logic                   r_all;

   // Leading ones are counted as leading zeros of the inverted operand.
   always_comb begin
      w_x = data_i;
      case (mode_i)
         MODE_LZ: w_x = data_i;
         MODE_LO: w_x = ~data_i;
      endcase
   end

   // Per-nibble counts of the (possibly inverted) operand.
   always_comb begin
      w_in_nib = '0;
      for (int unsigned i = 0; i < NIB; i++) begin
         w_in_nib[i] = lzc_nib(w_x[4*i +: 4]);
      end
   end

   // Stall chain from the output back: a stage advances if empty or if the next one advances.
   always_comb begin
      w_adv = '0;
      w_adv[STAGES+1] = ready_i;
      for (int unsigned k = STAGES; k >= 1; k--) begin
         w_adv[k] = !r_v[k] || w_adv[k+1];
      end
   end

   // Valid bit feeding each stage: input valid for stage 1, previous stage otherwise.
   always_comb begin
      w_vin    = r_v << 1;
      w_vin[1] = valid_i;
   end

   // Stage valid bits load on advance and hold otherwise.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_v <= '0;
      end else begin
         for (int unsigned k = 1; k <= STAGES; k++) begin
            if (w_adv[k]) r_v[k] <= w_vin[k];
         end
      end
   end

   if (STAGES > 1) begin : g_pipe
      logic [W-1:0]       r_data [1:STAGES-1];
      lzc_nib_t [NIB-1:0] r_nib  [1:STAGES-1];

      // Payload registers: stage 1 captures the input, later stages shift along.
      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            for (int unsigned k = 1; k < STAGES; k++) begin
               r_data[k] <= '0;
               r_nib[k]  <= '0;
            end
         end else begin
            if (w_adv[1]) begin
               r_data[1] <= data_i;
               r_nib[1]  <= w_in_nib;
            end
            for (int unsigned k = 2; k < STAGES; k++) begin
               if (w_adv[k]) begin
                  r_data[k] <= r_data[k-1];
                  r_nib[k]  <= r_nib[k-1];
               end
            end
         end
      end

      assign w_src_data = r_data[STAGES-1];
      assign w_src_nib  = r_nib[STAGES-1];
   end else begin : g_comb
      assign w_src_data = data_i;
      assign w_src_nib  = w_in_nib;
   end

   // Heap-ordered merge tree: leaves hold nibbles MSB-first, node k merges 2k+1 (high) and 2k+2 (low).
   for (genvar gi = 0; gi < NIB; gi++) begin : g_leaf
      assign w_tcnt[NIB-1+gi] = CNT_W'(w_src_nib[NIB-1-gi].cnt);
      assign w_tall[NIB-1+gi] = w_src_nib[NIB-1-gi].all;
   end

   for (genvar gk = 0; gk < NIB - 1; gk++) begin : g_node
      lzc_merge #(.CW(CNT_W)) u_merge (
         .i_hi_cnt (w_tcnt[2*gk+1]),
         .i_hi_all (w_tall[2*gk+1]),
         .i_lo_cnt (w_tcnt[2*gk+2]),
         .i_lo_all (w_tall[2*gk+2]),
         .o_cnt    (w_tcnt[gk]),
         .o_all    (w_tall[gk])
      );
   end

   // Final stage: register the merged count and the normalised operand; a shift of W yields zero.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_cnt  <= '0;
         r_norm <= '0;
         r_all  <= 1'b0;
      end else if (w_adv[STAGES]) begin
         r_cnt  <= w_tcnt[0];
         r_norm <= w_src_data << w_tcnt[0];
         r_all  <= w_tall[0];
      end
   end

   assign ready_o = w_adv[1];
   assign valid_o = r_v[STAGES];
   assign cnt_o   = r_cnt;
   assign norm_o  = r_norm;
   assign all_o   = r_all;

endmodule
